// File: rtl/vga_write_arbiter.sv
// vga_write_arbiter: frame sequencer and round-robin pixel write arbiter; define VGA_WRITE_ARB_FIXED_PRIO_EN for fixed priority
module vga_write_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PIX_W   = 6,
    parameter int WIN_W   = 50,
    parameter int WIN_H   = 50,
    parameter int ADDR_W  = 12
) (
    input  logic                      clk_20,
    input  logic                      reset_n,
    input  logic                      frame_start_in,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*PIX_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      frame_go,
    output logic                      fb_wr_en,
    output logic [ADDR_W-1:0]         fb_wr_addr,
    output logic [PIX_W-1:0]          fb_wr_data,
    output logic                      frame_done,
    output logic                      busy,
    output logic                      overrun
);
    localparam int TOTAL = WIN_W * WIN_H;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   count, count_nxt;
    logic [PTR_W-1:0]   win;
    logic               found, xfer, in_range, last_px, abort;
    logic [ADDR_W-1:0]  sel_addr;
    logic [PIX_W-1:0]   sel_data;

`ifdef VGA_WRITE_ARB_FIXED_PRIO_EN
    // lowest-index valid requester wins
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                found = 1'b1;
                win   = PTR_W'(i);
            end
        end
    end
`else
    logic [PTR_W-1:0]     ptr;
    logic [2*NUM_REQ-1:0] rot;
    int                   idx;

    // search starts just after the last winner; rot[i] is requester ptr+1+i
    always_comb begin
        found = 1'b0;
        win   = ptr;
        idx   = 0;
        rot   = {req_valid, req_valid} >> (int'(ptr) + 1);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                idx   = int'(ptr) + 1 + i;
                idx   = idx >= NUM_REQ ? idx - NUM_REQ : idx;
                win   = PTR_W'(idx);
            end
        end
    end

    // pointer follows the most recent winner
    always_ff @(posedge clk_20 or negedge reset_n)
        if (!reset_n) ptr <= PTR_W'(NUM_REQ - 1);
        else if (xfer) ptr <= win;
`endif

    assign xfer      = found && state == ACTIVE;
    assign req_ready = xfer ? NUM_REQ'(1) << win : '0;
    assign sel_addr  = req_addr[int'(win)*ADDR_W +: ADDR_W];
    assign sel_data  = req_data[int'(win)*PIX_W +: PIX_W];
    assign in_range  = {1'b0, sel_addr} < (ADDR_W + 1)'(TOTAL);
    assign last_px   = xfer && in_range && count == CNT_W'(TOTAL - 1);
    assign abort     = frame_start_in && state == ACTIVE && !last_px;
    assign busy      = state == ACTIVE;
    assign frame_done = state == DONE;

    // a frame start always (re)opens a frame; otherwise the last in-range pixel closes it
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        if (frame_start_in) begin
            state_nxt = ACTIVE;
            count_nxt = '0;
        end else if (last_px) begin
            state_nxt = DONE;
        end else if (xfer && in_range) begin
            count_nxt = count + 1'b1;
        end
    end

    // state, pixel count, frame_go pulse and sticky overrun
    always_ff @(posedge clk_20 or negedge reset_n)
        if (!reset_n) begin
            state    <= IDLE;
            count    <= '0;
            frame_go <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            frame_go <= frame_start_in & ~frame_go;
            overrun  <= overrun | abort;
        end

    // registered write port; address and data hold between writes
    always_ff @(posedge clk_20 or negedge reset_n)
        if (!reset_n) begin
            fb_wr_en   <= 1'b0;
            fb_wr_addr <= '0;
            fb_wr_data <= '0;
        end else begin
            fb_wr_en <= xfer & in_range;
            if (xfer && in_range) begin
                fb_wr_addr <= sel_addr;
                fb_wr_data <= sel_data;
            end
        end
endmodule

// File: tb/tb_vga_write_arbiter.sv
// tb_vga_write_arbiter: randomized scoreboard bench for vga_write_arbiter
module tb_vga_write_arbiter;
    localparam int NUM_REQ = 2;
    localparam int PIX_W   = 6;
    localparam int WIN_W   = 50;
    localparam int WIN_H   = 50;
    localparam int ADDR_W  = 12;
    localparam int TOTAL   = WIN_W * WIN_H;
    localparam int HALF    = TOTAL / 2;

    logic                      clk_20 = 1'b0;
    logic                      reset_n = 1'b0;
    logic                      frame_start_in = 1'b0;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
    logic [NUM_REQ*PIX_W-1:0]  req_data = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      frame_go, fb_wr_en, frame_done, busy, overrun;
    logic [ADDR_W-1:0]         fb_wr_addr;
    logic [PIX_W-1:0]          fb_wr_data;

    vga_write_arbiter #(.NUM_REQ(NUM_REQ), .PIX_W(PIX_W), .WIN_W(WIN_W), .WIN_H(WIN_H), .ADDR_W(ADDR_W)) dut (
        .clk_20(clk_20), .reset_n(reset_n), .frame_start_in(frame_start_in),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .frame_go(frame_go), .fb_wr_en(fb_wr_en),
        .fb_wr_addr(fb_wr_addr), .fb_wr_data(fb_wr_data),
        .frame_done(frame_done), .busy(busy), .overrun(overrun)
    );

    always #5 clk_20 = ~clk_20;

    typedef struct {
        logic [NUM_REQ-1:0] rdy;
        logic               go, we, done, bsy, ovr;
        logic [ADDR_W-1:0]  a;
        logic [PIX_W-1:0]   d;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    int               src_a [NUM_REQ][TOTAL+1];
    logic [PIX_W-1:0] src_d [NUM_REQ][TOTAL+1];
    int               head [NUM_REQ];
    int               tail [NUM_REQ];
    bit               hold [NUM_REQ];

    int               m_state, m_count, m_last, n_wr;
    bit               m_go, m_ovr, m_we, final_seen;
    logic [ADDR_W-1:0] m_a;
    logic [PIX_W-1:0]  m_d;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
        end
    endtask

    task automatic timeout(input string nm);
        tests++;
        fails++;
        $display("FAIL timeout %s at %0t", nm, $time);
    endtask

    task automatic check_zero(input string nm);
        check({nm, " req_ready"}, 32'(req_ready), 0);
        check({nm, " frame_go"}, 32'(frame_go), 0);
        check({nm, " fb_wr_en"}, 32'(fb_wr_en), 0);
        check({nm, " fb_wr_addr"}, 32'(fb_wr_addr), 0);
        check({nm, " fb_wr_data"}, 32'(fb_wr_data), 0);
        check({nm, " frame_done"}, 32'(frame_done), 0);
        check({nm, " busy"}, 32'(busy), 0);
        check({nm, " overrun"}, 32'(overrun), 0);
    endtask

    task automatic model_reset();
        m_state = 0;
        m_count = 0;
        m_last  = NUM_REQ - 1;
        m_go    = 0;
        m_ovr   = 0;
        m_we    = 0;
        m_a     = '0;
        m_d     = '0;
    endtask

    // core0 owns the first half of the window, core1 the second; optional out-of-range lead pixel
    task automatic load_frame(input bit oor);
        for (int k = 0; k < NUM_REQ; k++) begin
            head[k] = 0;
            tail[k] = 0;
            hold[k] = 0;
        end
        if (oor) begin
            src_a[0][0] = TOTAL;
            src_d[0][0] = 6'h3F;
            tail[0] = 1;
        end
        for (int p = 0; p < TOTAL; p++) begin
            int k;
            k = p < HALF ? 0 : 1;
            src_a[k][tail[k]] = p;
            src_d[k][tail[k]] = PIX_W'($urandom);
            tail[k]++;
        end
    endtask

    // one clock of stimulus: drive inputs, predict this cycle's outputs, advance the reference
    task automatic step(input bit fs_in, input bit rnd, input bit fs_on_final);
        exp_t               e;
        logic [NUM_REQ-1:0] v;
        int                 win;
        bit                 inr, fin, fs;
        @(negedge clk_20);
        for (int k = 0; k < NUM_REQ; k++) begin
            v[k] = head[k] < tail[k] && (hold[k] || !rnd || $urandom_range(1, 0) == 1);
            hold[k] = v[k];
            req_addr[k*ADDR_W +: ADDR_W] = head[k] < tail[k] ? ADDR_W'(src_a[k][head[k]]) : '0;
            req_data[k*PIX_W +: PIX_W]   = head[k] < tail[k] ? src_d[k][head[k]] : '0;
        end
        req_valid = v;
        e.go   = m_go;
        e.we   = m_we;
        e.a    = m_a;
        e.d    = m_d;
        e.done = m_state == 2;
        e.bsy  = m_state == 1;
        e.ovr  = m_ovr;
        win = -1;
        if (m_state == 1) begin
`ifdef VGA_WRITE_ARB_FIXED_PRIO_EN
            for (int i = NUM_REQ - 1; i >= 0; i--) if (v[i]) win = i;
`else
            for (int i = 1; i <= NUM_REQ; i++)
                if (win < 0 && v[(m_last + i) % NUM_REQ]) win = (m_last + i) % NUM_REQ;
`endif
        end
        e.rdy = win >= 0 ? NUM_REQ'(1) << win : '0;
        inr = win >= 0 && src_a[win][head[win]] < TOTAL;
        fin = inr && m_count == TOTAL - 1;
        fs  = fs_in || (fs_on_final && fin);
        if (fs_on_final && fin) final_seen = 1;
        frame_start_in = fs;
        exp_q.push_back(e);
        m_we = inr;
        if (inr) begin
            m_a = ADDR_W'(src_a[win][head[win]]);
            m_d = src_d[win][head[win]];
            n_wr++;
        end
        if (win >= 0) begin
            head[win]++;
            hold[win] = 0;
            m_last = win;
        end
        if (fs) begin
            if (m_state == 1 && !fin) m_ovr = 1;
            m_state = 1;
            m_count = 0;
        end else if (fin) m_state = 2;
        else if (inr) m_count++;
        m_go = fs && !m_go;
    endtask

    task automatic run_until_done(input bit rnd, input int bound, input string nm);
        for (int c = 0; c < bound && m_state != 2; c++) step(0, rnd, 0);
        if (m_state != 2) timeout(nm);
    endtask

    // monitor: compares DUT outputs against each queued expectation late in the cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_20);
            #4;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("req_ready", 32'(req_ready), 32'(e.rdy));
                check("frame_go", 32'(frame_go), 32'(e.go));
                check("fb_wr_en", 32'(fb_wr_en), 32'(e.we));
                check("frame_done", 32'(frame_done), 32'(e.done));
                check("busy", 32'(busy), 32'(e.bsy));
                check("overrun", 32'(overrun), 32'(e.ovr));
                if (e.we) begin
                    check("fb_wr_addr", 32'(fb_wr_addr), 32'(e.a));
                    check("fb_wr_data", 32'(fb_wr_data), 32'(e.d));
                end
            end
        end
    end

    initial begin
        model_reset();
        n_wr = 0;
        final_seen = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            head[k] = 0;
            tail[k] = 0;
            hold[k] = 0;
        end
        #2;
        check_zero("por");
        @(negedge clk_20);
        reset_n = 1'b1;

        // full frame, both cores always valid
        load_frame(0);
        step(1, 0, 0);
        run_until_done(0, 3000, "frame_a");
        repeat (3) step(0, 0, 0);

        // out-of-range lead pixel, random valids, abort after 100 writes, then a full frame
        load_frame(1);
        n_wr = 0;
        step(1, 1, 0);
        for (int c = 0; c < 1000 && n_wr < 100; c++) step(0, 1, 0);
        if (n_wr < 100) timeout("pre_abort");
        step(1, 1, 0);
        load_frame(0);
        run_until_done(1, 8000, "frame_b");
        repeat (2) step(0, 0, 0);

        // overrun persists into the next frame; reset lands on a write cycle
        load_frame(0);
        step(1, 1, 0);
        repeat (300) step(0, 1, 0);
        for (int c = 0; c < 100 && !m_we; c++) step(0, 1, 0);
        @(negedge clk_20);
        check("wr_before_reset", 32'(fb_wr_en), 32'(m_we));
        reset_n = 1'b0;
        #1;
        check_zero("mid_reset");
        model_reset();
        @(negedge clk_20);
        reset_n = 1'b1;
        repeat (5) step(0, 1, 0);

        // final pixel coincides with a new frame start
        load_frame(0);
        final_seen = 0;
        step(1, 1, 0);
        for (int c = 0; c < 8000 && !final_seen; c++) step(0, 1, 1);
        if (!final_seen) timeout("final_with_start");
        repeat (3) step(0, 0, 0);

        repeat (2) @(negedge clk_20);
        #5;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vga_write_arbiter.md
Name: vga_write_arbiter

Overview:
- Shares the display frame-buffer write port (50x50 window, 6-bit pixels, 2500 entries) between NUM_REQ pixel-producing GPU cores.
- Sequences each frame: waits for the display's buffer-swap pulse, kicks the cores, then round-robin arbitrates their addressed pixel writes into the write buffer.
- Reports frame completion and overruns.
- Sits between the shader cores and the VGA controller's write side, in the clk_20 domain.

Parameters:
- NUM_REQ, 2, number of requesting cores (2..8)
- PIX_W, 6, pixel width (RRGGBB)
- WIN_W, 50, window width in pixels
- WIN_H, 50, window height in pixels
- ADDR_W, 12, frame-buffer address width; must satisfy 2^ADDR_W >= WIN_W*WIN_H

Ports:
- clk_20  in  1  system clock; all logic is on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- frame_start_in  in  1  one-cycle pulse from the display: buffers swapped, a new frame may be written
- req_valid  in  NUM_REQ  per-core write request
- req_addr  in  NUM_REQ*ADDR_W  per-core linear pixel address (y*WIN_W+x); slice k belongs to core k
- req_data  in  NUM_REQ*PIX_W  per-core pixel; slice k belongs to core k
- req_ready  out  NUM_REQ  one-hot grant, combinational
- frame_go  out  1  one-cycle pulse telling the cores to start rendering
- fb_wr_en  out  1  frame-buffer write strobe, registered
- fb_wr_addr  out  ADDR_W  write address, registered
- fb_wr_data  out  PIX_W  write data, registered
- frame_done  out  1  level: all WIN_W*WIN_H pixels of the current frame written
- busy  out  1  high in ACTIVE
- overrun  out  1  sticky: a frame was aborted before completion

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, pixel count=0, rr pointer=NUM_REQ-1.
  - All outputs are 0: req_ready, frame_go, fb_wr_en, fb_wr_addr, fb_wr_data, frame_done, busy, overrun.
  - Reset mid-frame discards all progress; no write is issued after reset_n is asserted.
- FSM IDLE -> ACTIVE -> DONE -> ACTIVE.
  - IDLE: no grants. frame_start_in -> ACTIVE, frame_go=1 next cycle, count=0.
  - ACTIVE: busy=1. Grants one requester per cycle, chosen round-robin: search from pointer+1 modulo NUM_REQ; the first requester with valid=1 wins; the pointer moves to the winner. A transfer occurs when req_valid[k] & req_ready[k]. Requesters hold addr/data stable until granted.
  - DONE: frame_done=1, no grants. frame_start_in -> ACTIVE, frame_go pulse, count=0, frame_done cleared next cycle.
- Write path, latency 1:
  - A transfer in cycle N gives fb_wr_en=1 in cycle N+1, with the granted addr/data.
  - fb_wr_en=0 on cycles with no transfer; fb_wr_addr/data hold their last values.
- Count and range:
  - count increments on each transfer with addr < WIN_W*WIN_H.
  - Out-of-range addr: the request is still granted (consumed), but no fb_wr_en is issued and count is unchanged.
  - Duplicate addresses are written again and still counted; cores must not duplicate.
- Completion:
  - The transfer that brings count to WIN_W*WIN_H moves the FSM to DONE.
  - frame_done rises in the same cycle as that final fb_wr_en.
- Abort:
  - frame_start_in in ACTIVE with count < total (and no final transfer that cycle): overrun<=1 (sticky until reset), count=0, frame_go pulse, remain ACTIVE.
  - A transfer in that same cycle is still written.
- Simultaneous final transfer and frame_start_in: the pixel is written, no overrun, new frame starts (ACTIVE, count=0, frame_go pulse). frame_done stays 0.
- frame_go is never high two consecutive cycles.

Optional Feature:
- Macro VGA_WRITE_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest index with valid=1 always wins; the pointer is unused.
- Undefined (default): round-robin as above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then pulse frame_start_in -> frame_go high exactly 1 cycle, busy=1, frame_done=0, overrun=0.
- Both cores valid continuously, core0 addrs 0..1249, core1 addrs 1250..2499 -> grants alternate 0,1,0,1 starting with core0. 2500 fb_wr_en pulses, each one cycle after its grant. frame_done rises with the 2500th write; busy falls.
- Same as above with VGA_WRITE_ARB_FIXED_PRIO_EN defined -> core0 granted for 1250 consecutive cycles, then core1 for 1250.
- Core0 presents addr 2500 with data 6'h3F -> req_ready[0]=1, no fb_wr_en, count unchanged; frame still completes only after 2500 in-range writes.
- frame_start_in after 100 writes -> overrun=1, count restarts; 2500 further writes are required for frame_done. overrun stays 1 through the next frame.
- Assert reset_n low while fb_wr_en=1 mid-frame -> all outputs 0 immediately, state IDLE; grants resume only after a new frame_start_in.
